// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle MIPS-subset controller.
// Holds the controller state enum, the opcode/funct field values, the ALU function
// codes, the datapath mux encodings and the opcode class record produced by the
// decoder sub-module.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    RST    = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MADDR  = 4'd3,
    MRD    = 4'd4,
    MWB    = 4'd5,
    MWR    = 4'd6,
    BRANCH = 4'd7,
    EXEC   = 4'd8,
    AWB    = 4'd9,
    EXCEPT = 4'd10
  } state_e;

  // Opcode field values
  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] BLTZ   = 6'b000001;
  localparam logic [5:0] J      = 6'b000010;
  localparam logic [5:0] JAL    = 6'b000011;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] BNE    = 6'b000101;
  localparam logic [5:0] ADDI   = 6'b001000;
  localparam logic [5:0] SLTI   = 6'b001010;
  localparam logic [5:0] ANDI   = 6'b001100;
  localparam logic [5:0] ORI    = 6'b001101;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;

  // Funct field values
  localparam logic [5:0] F_JR      = 6'b001000;
  localparam logic [5:0] F_SYSCALL = 6'b001100;
  localparam logic [5:0] F_ADD     = 6'b100000;
  localparam logic [5:0] F_SUB     = 6'b100010;

  // ALU function codes
  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;
  localparam logic [5:0] ALU_SLT = 6'b101010;

  // Datapath mux encodings
  localparam logic [1:0] PC_JUMP   = 2'b00;
  localparam logic [1:0] PC_REG    = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;

  localparam logic [1:0] DST_RD = 2'b00;
  localparam logic [1:0] DST_RT = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] IN_MEM = 2'b00;
  localparam logic [1:0] IN_ALU = 2'b01;
  localparam logic [1:0] IN_PC  = 2'b10;

  localparam logic [1:0] Y_RT    = 2'b00;
  localparam logic [1:0] Y_FOUR  = 2'b01;
  localparam logic [1:0] Y_SEXT  = 2'b10;
  localparam logic [1:0] Y_SHIFT = 2'b11;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_OVFL    = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL = 2'b10;

  // Instruction class flags shared by next-state and output logic
  typedef struct packed {
    logic is_mem;     // lw or sw
    logic is_lw;
    logic is_branch;  // j, jal, jr, beq, bne, bltz
    logic is_jump;    // j or jal
    logic is_jal;
    logic is_jr;
    logic is_beq;
    logic is_bne;
    logic is_bltz;
    logic is_rtype;
    logic is_exec;    // ALU op through EXEC/AWB
    logic is_illegal;
    logic ovfl_op;    // add, sub, addi: may trap on overflow
  } op_class_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational opcode/funct classifier.
// Ports:
//   op_i       opcode field
//   fn_i       funct field
//   cls_o      instruction class flags
//   imm_func_o ALU function for immediate ALU ops (addi/andi/ori/slti)
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int FNC_W = 6
) (
  input  logic [OPC_W-1:0] op_i,
  input  logic [FNC_W-1:0] fn_i,
  output op_class_t        cls_o,
  output logic [FNC_W-1:0] imm_func_o
);

  logic rtype, is_lw, is_sw, is_j, is_jal, is_jr, is_syscall;
  logic is_beq, is_bne, is_bltz, is_imm;

  assign rtype      = (op_i == OPC_W'(R_TYPE));
  assign is_lw      = (op_i == OPC_W'(LW));
  assign is_sw      = (op_i == OPC_W'(SW));
  assign is_j       = (op_i == OPC_W'(J));
  assign is_jal     = (op_i == OPC_W'(JAL));
  assign is_beq     = (op_i == OPC_W'(BEQ));
  assign is_bne     = (op_i == OPC_W'(BNE));
  assign is_bltz    = (op_i == OPC_W'(BLTZ));
  assign is_jr      = rtype && (fn_i == FNC_W'(F_JR));
  assign is_syscall = rtype && (fn_i == FNC_W'(F_SYSCALL));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    is_imm     = 1'b1;
    imm_func_o = FNC_W'(ALU_ADD);
    case (op_i)
      OPC_W'(ADDI): imm_func_o = FNC_W'(ALU_ADD);
      OPC_W'(ANDI): imm_func_o = FNC_W'(ALU_AND);
      OPC_W'(ORI):  imm_func_o = FNC_W'(ALU_OR);
      OPC_W'(SLTI): imm_func_o = FNC_W'(ALU_SLT);
      default:      is_imm     = 1'b0;
    endcase
  end

  always_comb begin
    cls_o            = '0;
    cls_o.is_mem     = is_lw || is_sw;
    cls_o.is_lw      = is_lw;
    cls_o.is_jump    = is_j || is_jal;
    cls_o.is_jal     = is_jal;
    cls_o.is_jr      = is_jr;
    cls_o.is_beq     = is_beq;
    cls_o.is_bne     = is_bne;
    cls_o.is_bltz    = is_bltz;
    cls_o.is_branch  = is_j || is_jal || is_jr || is_beq || is_bne || is_bltz;
    cls_o.is_rtype   = rtype;
    cls_o.is_exec    = (rtype && !is_jr && !is_syscall) || is_imm;
    cls_o.is_illegal = !(rtype || is_lw || is_sw || is_j || is_jal ||
                         is_beq || is_bne || is_bltz || is_imm);
    cls_o.ovfl_op    = (rtype && (fn_i == FNC_W'(F_ADD) || fn_i == FNC_W'(F_SUB))) ||
                       (op_i == OPC_W'(ADDI));
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control unit for the MIPS-subset datapath.
// Drives datapath mux selects and write enables from the controller state and the
// opcode/funct latched in DECODE; handles memory wait states, branch resolution and
// overflow / illegal-opcode traps.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   opc, fnc                      IR opcode / funct
//   mem_ready                     memory access completes this cycle
//   alu_zero, alu_neg, alu_ovfl   ALU status flags
//   pc_write, inst_data, mem_read, mem_write, ir_write, reg_dst, reg_in_src,
//   reg_write, alu_src_x, alu_src_y, alu_func, pc_src, jump_addr, epc_write
//                                 datapath controls
//   exc_cause                     cause of the most recent trap
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W  = 6,
  parameter int FNC_W  = 6,
  parameter bit EXC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opc,
  input  logic [FNC_W-1:0] fnc,
  input  logic             mem_ready,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_ovfl,
  output logic             pc_write,
  output logic             inst_data,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       reg_in_src,
  output logic             reg_write,
  output logic             alu_src_x,
  output logic [1:0]       alu_src_y,
  output logic [FNC_W-1:0] alu_func,
  output logic [1:0]       pc_src,
  output logic             jump_addr,
  output logic             epc_write,
  output logic [1:0]       exc_cause
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic [FNC_W-1:0] fn_q, fn_d;
  logic [1:0]       exc_cause_q, exc_cause_d;

  // In DECODE the IR fields are not yet latched, so classify the live IR.
  logic [OPC_W-1:0] dec_op;
  logic [FNC_W-1:0] dec_fn;
  op_class_t        cls;
  logic [FNC_W-1:0] imm_func;

  assign dec_op = (state_q == DECODE) ? opc : op_q;
  assign dec_fn = (state_q == DECODE) ? fnc : fn_q;

  mc_ctrl_decode #(
    .OPC_W (OPC_W),
    .FNC_W (FNC_W)
  ) u_decode (
    .op_i       (dec_op),
    .fn_i       (dec_fn),
    .cls_o      (cls),
    .imm_func_o (imm_func)
  );

  logic ovfl_trap, br_taken;
  assign ovfl_trap = EXC_EN && alu_ovfl && cls.ovfl_op;
  assign br_taken  = (cls.is_beq && alu_zero) || (cls.is_bne && !alu_zero) ||
                     (cls.is_bltz && alu_neg);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: op_q/fn_q are reset too so the decode seen in RST/FETCH is never X.
      state_q     <= RST;
      op_q        <= '0;
      fn_q        <= '0;
      exc_cause_q <= EXC_NONE;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      op_q        <= op_d;
      fn_q        <= fn_d;
      exc_cause_q <= exc_cause_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    fn_d        = fn_q;
    exc_cause_d = exc_cause_q;
    case (state_q)
      RST:    state_d = FETCH;
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        op_d = opc;
        fn_d = fnc;
        if (cls.is_mem)                      state_d = MADDR;
        else if (cls.is_branch)              state_d = BRANCH;
        else if (cls.is_exec)                state_d = EXEC;
        else if (cls.is_illegal && EXC_EN) begin
          state_d     = EXCEPT;
          exc_cause_d = EXC_ILLEGAL;
        end else                             state_d = FETCH; // syscall, or illegal as NOP
      end
      MADDR:  state_d = cls.is_lw ? MRD : MWR;
      MRD:    if (mem_ready) state_d = MWB;
      MWB:    state_d = FETCH;
      MWR:    if (mem_ready) state_d = FETCH;
      BRANCH: state_d = FETCH;
      EXEC:   state_d = AWB;
      AWB: begin
        if (ovfl_trap) begin
          state_d     = EXCEPT;
          exc_cause_d = EXC_OVFL;
        end else begin
          state_d = FETCH;
        end
      end
      EXCEPT:  state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  assign exc_cause = exc_cause_q;

  // Output decode
  always_comb begin
    pc_write   = 1'b0;
    inst_data  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = DST_RD;
    reg_in_src = IN_MEM;
    reg_write  = 1'b0;
    alu_src_x  = 1'b0;
    alu_src_y  = Y_RT;
    alu_func   = '0;
    pc_src     = PC_JUMP;
    jump_addr  = 1'b0;
    epc_write  = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_y = Y_FOUR;
        alu_func  = FNC_W'(ALU_ADD);
        ir_write  = mem_ready;
        pc_write  = mem_ready;   // pc_src stays PC_JUMP: PC + 4 through the ALU path
      end
      DECODE: begin
        alu_src_y = Y_SHIFT;
        alu_func  = FNC_W'(ALU_ADD);
      end
      MADDR: begin
        alu_src_x = 1'b1;
        alu_src_y = Y_SEXT;
        alu_func  = FNC_W'(ALU_ADD);
      end
      MRD: begin
        inst_data = 1'b1;
        mem_read  = 1'b1;
      end
      MWB: begin
        reg_dst    = DST_RT;
        reg_in_src = IN_MEM;
        reg_write  = 1'b1;
      end
      MWR: begin
        inst_data = 1'b1;
        mem_write = 1'b1;
      end
      BRANCH: begin
        alu_src_x = 1'b1;
        alu_src_y = Y_RT;
        alu_func  = FNC_W'(ALU_SUB);
        if (cls.is_jr) begin
          pc_write  = 1'b1;
          pc_src    = PC_REG;
          jump_addr = 1'b1;
        end else if (cls.is_jump) begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
          if (cls.is_jal) begin
            reg_write  = 1'b1;
            reg_dst    = DST_RA;
            reg_in_src = IN_PC;
          end
        end else begin
          pc_write = br_taken;
          pc_src   = PC_BRANCH;
        end
      end
      EXEC, AWB: begin
        alu_src_x = 1'b1;
        alu_src_y = cls.is_rtype ? Y_RT : Y_SEXT;
        alu_func  = cls.is_rtype ? fn_q : imm_func;
        if (state_q == AWB) begin
          reg_in_src = IN_ALU;
          reg_dst    = cls.is_rtype ? DST_RD : DST_RT;
          reg_write  = !ovfl_trap;
        end
      end
      EXCEPT: begin
        epc_write = 1'b1;
        pc_src    = PC_EXC;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: self-checking bench for mc_ctrl_fsm.
// Each instruction is run from its first FETCH cycle to the next FETCH while the
// per-instruction activity (cycle count, strobe counts, mux selects at the strobe)
// is tallied and compared with an instruction-level model of the controller.
// A second instance with traps disabled checks the NOP / no-trap behaviour.
module tb_mc_ctrl_fsm;

  localparam logic [5:0] OP_R    = 6'b000000, OP_BLTZ = 6'b000001, OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011, OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101, OP_LW   = 6'b100011, OP_SW   = 6'b101011;
  localparam logic [5:0] FN_JR   = 6'b001000, FN_SYS  = 6'b001100;
  localparam logic [5:0] FN_ADD  = 6'b100000, FN_SUB  = 6'b100010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] opc, fnc;
  logic       mem_ready, alu_zero, alu_neg, alu_ovfl;
  logic       pc_write, inst_data, mem_read, mem_write, ir_write, reg_write;
  logic       alu_src_x, jump_addr, epc_write;
  logic [1:0] reg_dst, reg_in_src, alu_src_y, pc_src, exc_cause;
  logic [5:0] alu_func;

  logic [5:0] opc0, fnc0;
  logic       mr0, ovfl0;
  logic       pc_write0, inst_data0, mem_read0, mem_write0, ir_write0, reg_write0;
  logic       alu_src_x0, jump_addr0, epc_write0;
  logic [1:0] reg_dst0, reg_in_src0, alu_src_y0, pc_src0, exc_cause0;
  logic [5:0] alu_func0;

  mc_ctrl_fsm #(.OPC_W(6), .FNC_W(6), .EXC_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opc(opc), .fnc(fnc), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovfl(alu_ovfl),
    .pc_write(pc_write), .inst_data(inst_data), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .reg_in_src(reg_in_src), .reg_write(reg_write),
    .alu_src_x(alu_src_x), .alu_src_y(alu_src_y), .alu_func(alu_func), .pc_src(pc_src),
    .jump_addr(jump_addr), .epc_write(epc_write), .exc_cause(exc_cause)
  );

  mc_ctrl_fsm #(.OPC_W(6), .FNC_W(6), .EXC_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .opc(opc0), .fnc(fnc0), .mem_ready(mr0),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovfl(ovfl0),
    .pc_write(pc_write0), .inst_data(inst_data0), .mem_read(mem_read0), .mem_write(mem_write0),
    .ir_write(ir_write0), .reg_dst(reg_dst0), .reg_in_src(reg_in_src0), .reg_write(reg_write0),
    .alu_src_x(alu_src_x0), .alu_src_y(alu_src_y0), .alu_func(alu_func0), .pc_src(pc_src0),
    .jump_addr(jump_addr0), .epc_write(epc_write0), .exc_cause(exc_cause0)
  );

  logic [24:0] outs;
  assign outs = {pc_write, inst_data, mem_read, mem_write, ir_write, reg_dst, reg_in_src,
                 reg_write, alu_src_x, alu_src_y, alu_func, pc_src, jump_addr, epc_write,
                 exc_cause};

  int n_checks = 0;
  int n_fail   = 0;
  int n_instr  = 0;
  logic [1:0] cause_m = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         cyc, n_rw, n_pcw, n_mw, n_dr, n_epc, n_ja;
    logic [1:0] rdst, rsrc, pcsrc, cause, ysel;
    bit         has_alu;
    logic [5:0] func;
  } exp_t;

  // Instruction-level model: what one instruction does from FETCH to the next FETCH.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input bit z, input bit n, input bit o,
                                 input int wf, input int wm, input logic [1:0] cause_in);
    exp_t e;
    bit is_r, is_imm, is_cond, taken, trap;
    e.cyc = 2 + wf;  e.n_rw = 0; e.n_pcw = 1; e.n_mw = 0; e.n_dr = 0; e.n_epc = 0; e.n_ja = 0;
    e.rdst = 2'b00;  e.rsrc = 2'b00; e.pcsrc = 2'b00; e.cause = cause_in; e.ysel = 2'b00;
    e.has_alu = 1'b0; e.func = 6'b0;
    is_r    = (op == OP_R);
    is_imm  = op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
    is_cond = op inside {OP_BEQ, OP_BNE, OP_BLTZ};
    if (op == OP_LW) begin
      e.cyc += 3 + wm; e.has_alu = 1'b1; e.func = 6'b100000; e.ysel = 2'b10;
      e.n_dr = 1 + wm; e.n_rw = 1; e.rdst = 2'b01; e.rsrc = 2'b00;
    end else if (op == OP_SW) begin
      e.cyc += 2 + wm; e.has_alu = 1'b1; e.func = 6'b100000; e.ysel = 2'b10;
      e.n_mw = 1 + wm;
    end else if (op == OP_J || op == OP_JAL || is_cond || (is_r && fn == FN_JR)) begin
      e.cyc += 1; e.has_alu = 1'b1; e.func = 6'b100010; e.ysel = 2'b00;
      taken = !is_cond || (op == OP_BEQ && z) || (op == OP_BNE && !z) || (op == OP_BLTZ && n);
      if (taken) begin
        e.n_pcw = 2;
        e.pcsrc = is_r ? 2'b01 : (is_cond ? 2'b10 : 2'b00);
      end
      if (op == OP_JAL) begin e.n_rw = 1; e.rdst = 2'b10; e.rsrc = 2'b10; end
      if (is_r) e.n_ja = 1;
    end else if (is_r && fn == FN_SYS) begin
      e.cyc += 0;
    end else if (is_r || is_imm) begin
      e.cyc += 2; e.has_alu = 1'b1; e.ysel = is_r ? 2'b00 : 2'b10;
      case (op)
        OP_ADDI: e.func = 6'b100000;
        OP_ANDI: e.func = 6'b100100;
        OP_ORI:  e.func = 6'b100101;
        OP_SLTI: e.func = 6'b101010;
        default: e.func = fn;
      endcase
      trap = o && ((is_r && (fn == FN_ADD || fn == FN_SUB)) || op == OP_ADDI);
      if (trap) begin
        e.cyc += 1; e.n_pcw = 2; e.pcsrc = 2'b11; e.n_epc = 1; e.cause = 2'b01;
      end else begin
        e.n_rw = 1; e.rdst = is_r ? 2'b00 : 2'b01; e.rsrc = 2'b01;
      end
    end else begin
      e.cyc += 1; e.n_pcw = 2; e.pcsrc = 2'b11; e.n_epc = 1; e.cause = 2'b10;
    end
    return e;
  endfunction

  // Entered at posedge+1 of an instruction's first FETCH cycle; returns at the same
  // point of the following instruction's FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                           input int wm, input bit z, input bit n, input bit o);
    exp_t e;
    int cyc = 0, f_cnt = 0, d_cnt = 0;
    int n_ir = 0, n_rw = 0, n_pcw = 0, n_mw = 0, n_dr = 0, n_epc = 0, n_ja = 0;
    logic [1:0] rdst = 2'b00, rsrc = 2'b00, pcsrc = 2'b00, ysel = 2'b00;
    logic [5:0] func = 6'b0;
    bit seen_alu = 1'b0, done = 1'b0, prev_fetch = 1'b0, fetch_now, data_now;
    string t;
    n_instr++;
    t = $sformatf("i%0d(op=%b,fn=%b)", n_instr, op, fn);
    e = model(op, fn, z, n, o, wf, wm, cause_m);
    cause_m = e.cause;
    opc = op; fnc = fn; alu_zero = z; alu_neg = n; alu_ovfl = o;
    for (int k = 0; k < 40 && !done; k++) begin
      fetch_now = mem_read && !inst_data;
      if (k > 0 && fetch_now && !prev_fetch) begin
        done = 1'b1;
      end else begin
        data_now = (mem_read && inst_data) || mem_write;
        if (fetch_now)     begin mem_ready = (f_cnt == wf); f_cnt++; end
        else if (data_now) begin mem_ready = (d_cnt == wm); d_cnt++; end
        else               mem_ready = 1'($urandom_range(0, 1));
        #3;
        cyc++;
        if (ir_write)            n_ir++;
        if (mem_write)           n_mw++;
        if (mem_read && inst_data) n_dr++;
        if (epc_write)           n_epc++;
        if (jump_addr)           n_ja++;
        if (reg_write) begin n_rw++; rdst = reg_dst; rsrc = reg_in_src; end
        if (pc_write)  begin n_pcw++; pcsrc = pc_src; end
        if (alu_src_x) begin seen_alu = 1'b1; func = alu_func; ysel = alu_src_y; end
        prev_fetch = fetch_now;
        @(posedge clk); #1;
      end
    end
    check({t, ".finished"}, 32'(done), 32'd1);
    check({t, ".cycles"}, 32'(cyc), 32'(e.cyc));
    check({t, ".ir_write"}, 32'(n_ir), 32'd1);
    check({t, ".reg_write"}, 32'(n_rw), 32'(e.n_rw));
    check({t, ".pc_write"}, 32'(n_pcw), 32'(e.n_pcw));
    check({t, ".pc_src"}, 32'(pcsrc), 32'(e.pcsrc));
    check({t, ".mem_write"}, 32'(n_mw), 32'(e.n_mw));
    check({t, ".data_read"}, 32'(n_dr), 32'(e.n_dr));
    check({t, ".epc_write"}, 32'(n_epc), 32'(e.n_epc));
    check({t, ".jump_addr"}, 32'(n_ja), 32'(e.n_ja));
    check({t, ".exc_cause"}, 32'(exc_cause), 32'(e.cause));
    check({t, ".alu_used"}, 32'(seen_alu), 32'(e.has_alu));
    if (e.n_rw != 0) begin
      check({t, ".reg_dst"}, 32'(rdst), 32'(e.rdst));
      check({t, ".reg_in_src"}, 32'(rsrc), 32'(e.rsrc));
    end
    if (e.has_alu) begin
      check({t, ".alu_func"}, 32'(func), 32'(e.func));
      check({t, ".alu_src_y"}, 32'(ysel), 32'(e.ysel));
    end
  endtask

  logic [5:0] op_tab [14] = '{OP_LW, OP_SW, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLTZ,
                              OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_R, OP_R, 6'b111111};
  logic [5:0] fn_tab [8]  = '{FN_ADD, FN_SUB, 6'b100100, 6'b100101, 6'b101010,
                              FN_JR, FN_SYS, 6'b100111};
  logic [5:0] ill_tab [4] = '{6'b111111, 6'b010000, 6'b000110, 6'b100000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_ir, cnt_strobe, cnt_rw, cnt_epc;
    rst_n = 1'b0; opc = '0; fnc = '0; mem_ready = 1'b0;
    alu_zero = 1'b0; alu_neg = 1'b0; alu_ovfl = 1'b0;
    opc0 = 6'b111111; fnc0 = '0; mr0 = 1'b1; ovfl0 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #4 check("reset.outputs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    #1 check("rst_state.outputs", 32'(outs), 32'd0);
    @(posedge clk); #1;
    check("first_fetch", 32'({mem_read, inst_data}), 32'b10);

    // Directed instructions
    run_instr(OP_LW,  6'b0,   0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(OP_SW,  6'b0,   0, 3, 1'b0, 1'b0, 1'b0);
    run_instr(OP_BEQ, 6'b0,   0, 0, 1'b1, 1'b0, 1'b0);
    run_instr(OP_BEQ, 6'b0,   0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(OP_BNE, 6'b0,   1, 0, 1'b0, 1'b0, 1'b0);
    run_instr(OP_R,   FN_ADD, 0, 0, 1'b0, 1'b0, 1'b1);
    run_instr(6'b111111, 6'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(OP_R,   FN_JR,  2, 0, 1'b0, 1'b0, 1'b0);
    run_instr(OP_JAL, 6'b0,   0, 0, 1'b1, 1'b1, 1'b1);
    run_instr(OP_BLTZ, 6'b0,  0, 0, 1'b0, 1'b1, 1'b0);
    run_instr(OP_ADDI, 6'b0,  0, 0, 1'b0, 1'b0, 1'b1);
    run_instr(OP_ORI, 6'b0,   0, 0, 1'b0, 1'b0, 1'b1);
    run_instr(OP_R,   FN_SYS, 1, 0, 1'b0, 1'b0, 1'b0);
    run_instr(OP_LW,  6'b0,   2, 2, 1'b0, 1'b0, 1'b0);

    // Randomized instructions, wait states and ALU flags
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op, fn;
      op = op_tab[$urandom_range(0, 13)];
      if (op == 6'b111111) op = ill_tab[$urandom_range(0, 3)];
      fn = fn_tab[$urandom_range(0, 7)];
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset during the second MRD wait cycle
    opc = OP_LW; mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;   // DECODE
    @(posedge clk); #1;                     // MADDR
    @(posedge clk); #1;                     // MRD, wait 1
    @(posedge clk); #1;                     // MRD, wait 2
    check("mrd.reading", 32'({mem_read, inst_data}), 32'b11);
    rst_n = 1'b0;
    #1 check("mrd.async_reset_outputs", 32'(outs), 32'd0);
    cause_m = 2'b00;
    @(posedge clk); #1;
    check("mrd.reset_held", 32'(outs), 32'd0);
    rst_n = 1'b1;
    #2 check("mrd.rst_state", 32'(outs), 32'd0);
    @(posedge clk); #1;
    check("mrd.fetch_after_reset", 32'({mem_read, inst_data}), 32'b10);
    check("dut0.fetch_after_reset", 32'({mem_read0, inst_data0}), 32'b10);

    // Traps disabled: illegal opcode behaves as NOP (FETCH, DECODE, FETCH, ...)
    cnt_ir = 0; cnt_strobe = 0;
    for (int k = 0; k < 12; k++) begin
      #3;
      if (ir_write0) cnt_ir++;
      if (reg_write0 || mem_write0 || epc_write0) cnt_strobe++;
      @(posedge clk); #1;
    end
    check("noexc.illegal_fetches", 32'(cnt_ir), 32'd6);
    check("noexc.illegal_strobes", 32'(cnt_strobe), 32'd0);
    check("noexc.illegal_cause", 32'(exc_cause0), 32'd0);

    // Traps disabled: overflowing add still writes back (FETCH, DECODE, EXEC, AWB)
    opc0 = OP_R; fnc0 = FN_ADD; ovfl0 = 1'b1;
    cnt_rw = 0; cnt_epc = 0;
    for (int k = 0; k < 12; k++) begin
      #3;
      if (reg_write0) cnt_rw++;
      if (epc_write0) cnt_epc++;
      @(posedge clk); #1;
    end
    check("noexc.ovfl_writes", 32'(cnt_rw), 32'd3);
    check("noexc.ovfl_epc", 32'(cnt_epc), 32'd0);
    check("noexc.ovfl_cause", 32'(exc_cause0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
